// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA timing pipeline: standard mode constants,
// the delay-line stage record and small elaboration-time helpers.
`timescale 1ns / 1ps

package vga_timing_pkg;

    // 1024x768 @ 60 Hz (65 MHz pixel clock)
    localparam int XGA_H_VISIBLE = 1024;
    localparam int XGA_H_FRONT   = 24;
    localparam int XGA_H_SYNC    = 136;
    localparam int XGA_H_BACK    = 144;
    localparam int XGA_V_VISIBLE = 768;
    localparam int XGA_V_FRONT   = 3;
    localparam int XGA_V_SYNC    = 6;
    localparam int XGA_V_BACK    = 29;
    localparam bit XGA_HSYNC_POL = 1'b0;
    localparam bit XGA_VSYNC_POL = 1'b0;

    // 640x480 @ 60 Hz (25.175 MHz pixel clock)
    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam bit VGA_HSYNC_POL = 1'b0;
    localparam bit VGA_VSYNC_POL = 1'b0;

    // One delay-line entry: visibility plus raw (active-high) sync flags.
    typedef struct packed {
        logic valid;
        logic hsync;
        logic vsync;
    } sync_stage_t;

    // Blank entry: not visible, neither sync active.
    localparam sync_stage_t BLANK_STAGE = '{valid: 1'b0, hsync: 1'b0, vsync: 1'b0};

    // Length of one line (or frame) in pixels (or lines).
    function automatic int total_len(input int visible, input int front,
                                     input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    // Width of a packed {R,G,B} pixel word.
    function automatic int pix_width(input int r_w, input int g_w, input int b_w);
        return r_w + g_w + b_w;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Single-axis timing counter: counts 0..TOTAL-1 while enabled and decodes
// the visible region and the raw (active-high) sync window of the current count.
`timescale 1ns / 1ps

module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE = 1024,
    parameter int FRONT   = 24,
    parameter int SYNC    = 136,
    parameter int BACK    = 144,
    parameter int CNT_W   = 11
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_first,
    output logic             o_last,
    output logic             o_visible,
    output logic             o_sync
);

    localparam int               TOTAL      = total_len(VISIBLE, FRONT, SYNC, BACK);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] VIS_END    = CNT_W'(VISIBLE);
    localparam logic [CNT_W-1:0] SYNC_BEGIN = CNT_W'(VISIBLE + FRONT);
    localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(VISIBLE + FRONT + SYNC);

    logic [CNT_W-1:0] r_cnt;

    // Position counter: advance on enable, wrap from TOTAL-1 back to 0.
    always_ff @(posedge i_clk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples pre-edge values and simulation order cannot change behaviour.
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt     = r_cnt;
    assign o_first   = (r_cnt == '0);
    assign o_last    = (r_cnt == LAST);
    assign o_visible = (r_cnt < VIS_END);
    assign o_sync    = (r_cnt >= SYNC_BEGIN) && (r_cnt < SYNC_END);

endmodule

// File: rtl/vga_timing_pipe.sv
// VGA timing generator with a pixel-request port: requests go out PIX_LATENCY
// pixel-cycles ahead, and sync/blank are delayed so returning pixel data lines up.
`timescale 1ns / 1ps

module vga_timing_pipe
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE   = XGA_H_VISIBLE,
    parameter int H_FRONT     = XGA_H_FRONT,
    parameter int H_SYNC      = XGA_H_SYNC,
    parameter int H_BACK      = XGA_H_BACK,
    parameter int V_VISIBLE   = XGA_V_VISIBLE,
    parameter int V_FRONT     = XGA_V_FRONT,
    parameter int V_SYNC      = XGA_V_SYNC,
    parameter int V_BACK      = XGA_V_BACK,
    parameter bit HSYNC_POL   = XGA_HSYNC_POL,
    parameter bit VSYNC_POL   = XGA_VSYNC_POL,
    parameter int PIX_LATENCY = 2,
    parameter int CNT_W       = 11,
    parameter int R_W         = 3,
    parameter int G_W         = 3,
    parameter int B_W         = 2
) (
    input  logic                     FCLK,
    input  logic                     RST_IN,
    input  logic                     PIX_CE,
    output logic [CNT_W-1:0]         REQ_X,
    output logic [CNT_W-1:0]         REQ_Y,
    output logic                     REQ_VALID,
    output logic                     LINE_START,
    output logic                     FRAME_START,
    input  logic [R_W+G_W+B_W-1:0]   PIXEL_DATA,
    output logic                     DISPLAY_EN,
    output logic                     HSYNC,
    output logic                     VSYNC,
    output logic [R_W-1:0]           R,
    output logic [G_W-1:0]           G,
    output logic [B_W-1:0]           B
);

    localparam int PIX_W = pix_width(R_W, G_W, B_W);

    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    logic             w_h_first;
    logic             w_h_last;
    logic             w_h_visible;
    logic             w_h_sync;
    logic             w_v_first;
    logic             w_v_visible;
    logic             w_v_sync;
    logic             w_unused_v_last;

    // Horizontal axis advances every pixel-cycle.
    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .CNT_W   (CNT_W)
    ) u_h_cnt (
        .i_clk     (FCLK),
        .i_rst     (RST_IN),
        .i_en      (PIX_CE),
        .o_cnt     (w_h_cnt),
        .o_first   (w_h_first),
        .o_last    (w_h_last),
        .o_visible (w_h_visible),
        .o_sync    (w_h_sync)
    );

    // Vertical axis advances only when the horizontal axis wraps; frame end is
    // implied by the (0,0) decode, so its last-line flag is not needed.
    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .CNT_W   (CNT_W)
    ) u_v_cnt (
        .i_clk     (FCLK),
        .i_rst     (RST_IN),
        .i_en      (PIX_CE && w_h_last),
        .o_cnt     (w_v_cnt),
        .o_first   (w_v_first),
        .o_last    (w_unused_v_last),
        .o_visible (w_v_visible),
        .o_sync    (w_v_sync)
    );

    logic [CNT_W-1:0] r_req_x;
    logic [CNT_W-1:0] r_req_y;
    logic             r_line_start;
    logic             r_frame_start;
    sync_stage_t      r_req;

    // Request stage: publish the current position and its raw timing flags.
    always_ff @(posedge FCLK) begin
        if (RST_IN) begin
            r_req_x       <= '0;
            r_req_y       <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_req         <= BLANK_STAGE;
        end else if (PIX_CE) begin
            r_req_x       <= w_h_cnt;
            r_req_y       <= w_v_cnt;
            r_line_start  <= w_h_first;
            r_frame_start <= w_h_first && w_v_first;
            r_req         <= '{valid: w_h_visible && w_v_visible,
                               hsync: w_h_sync,
                               vsync: w_v_sync};
        end
    end

    sync_stage_t r_dly [PIX_LATENCY];
    sync_stage_t w_dly_out;

    // Delay line: hold timing flags for PIX_LATENCY pixel-cycles while the
    // source fetches the requested pixel.
    always_ff @(posedge FCLK) begin
        // NOTE: this small shift register is reset, unlike a RAM, so the first
        // pixels after reset come out blank instead of replaying an old frame.
        if (RST_IN) begin
            for (int i = 0; i < PIX_LATENCY; i++) begin
                r_dly[i] <= BLANK_STAGE;
            end
        end else if (PIX_CE) begin
            r_dly[0] <= r_req;
            for (int i = 1; i < PIX_LATENCY; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    assign w_dly_out = r_dly[PIX_LATENCY-1];

    logic [PIX_W-1:0] w_rgb_next;

    // Colour is forced to black outside the visible area.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_rgb_next = '0;
        if (w_dly_out.valid) begin
            w_rgb_next = PIXEL_DATA;
        end
    end

    logic             r_display_en;
    logic             r_hsync;
    logic             r_vsync;
    logic [PIX_W-1:0] r_rgb;

    // Output register: sample pixel data together with its delayed timing.
    always_ff @(posedge FCLK) begin
        if (RST_IN) begin
            r_display_en <= 1'b0;
            r_hsync      <= ~HSYNC_POL;
            r_vsync      <= ~VSYNC_POL;
            r_rgb        <= '0;
        end else if (PIX_CE) begin
            r_display_en <= w_dly_out.valid;
            r_hsync      <= ~(w_dly_out.hsync ^ HSYNC_POL);
            r_vsync      <= ~(w_dly_out.vsync ^ VSYNC_POL);
            r_rgb        <= w_rgb_next;
        end
    end

    assign REQ_X       = r_req_x;
    assign REQ_Y       = r_req_y;
    assign REQ_VALID   = r_req.valid;
    assign LINE_START  = r_line_start;
    assign FRAME_START = r_frame_start;
    assign DISPLAY_EN  = r_display_en;
    assign HSYNC       = r_hsync;
    assign VSYNC       = r_vsync;
    assign R           = r_rgb[PIX_W-1 -: R_W];
    assign G           = r_rgb[G_W+B_W-1 -: G_W];
    assign B           = r_rgb[B_W-1:0];

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Bench for vga_timing_pipe: four instances (small mode, small mode with a
// toggling enable, small mode with active-high syncs and a mid-frame reset,
// and the default XGA mode) run side by side from one stimulus process.
// Expected observations are queued per instance and checked by a monitor.
`timescale 1ns / 1ps

module tb_vga_timing_pipe;

    localparam int NCYC = 4200;
    localparam int LAG  = 3;      // output lag behind REQ for PIX_LATENCY=2

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        rv;
        logic        ls;
        logic        fs;
        logic        de;
        logic        hs;
        logic        vs;
        logic [7:0]  rgb;
    } obs_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic fclk;
    initial begin
        fclk = 1'b0;
        forever #5 fclk = ~fclk;
    end

    // ---------------- DUT signals ----------------
    logic s_rst, s_ce; logic [7:0] s_pix; logic [10:0] s_x, s_y;
    logic s_rv, s_ls, s_fs, s_de, s_hs, s_vs; logic [2:0] s_r, s_g; logic [1:0] s_b;
    logic c_rst, c_ce; logic [7:0] c_pix; logic [10:0] c_x, c_y;
    logic c_rv, c_ls, c_fs, c_de, c_hs, c_vs; logic [2:0] c_r, c_g; logic [1:0] c_b;
    logic p_rst, p_ce; logic [7:0] p_pix; logic [10:0] p_x, p_y;
    logic p_rv, p_ls, p_fs, p_de, p_hs, p_vs; logic [2:0] p_r, p_g; logic [1:0] p_b;
    logic x_rst, x_ce; logic [7:0] x_pix; logic [10:0] x_x, x_y;
    logic x_rv, x_ls, x_fs, x_de, x_hs, x_vs; logic [2:0] x_r, x_g; logic [1:0] x_b;

    vga_timing_pipe #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIX_LATENCY(2), .CNT_W(11)
    ) u_small (
        .FCLK(fclk), .RST_IN(s_rst), .PIX_CE(s_ce), .REQ_X(s_x), .REQ_Y(s_y),
        .REQ_VALID(s_rv), .LINE_START(s_ls), .FRAME_START(s_fs), .PIXEL_DATA(s_pix),
        .DISPLAY_EN(s_de), .HSYNC(s_hs), .VSYNC(s_vs), .R(s_r), .G(s_g), .B(s_b)
    );

    vga_timing_pipe #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIX_LATENCY(2), .CNT_W(11)
    ) u_ce (
        .FCLK(fclk), .RST_IN(c_rst), .PIX_CE(c_ce), .REQ_X(c_x), .REQ_Y(c_y),
        .REQ_VALID(c_rv), .LINE_START(c_ls), .FRAME_START(c_fs), .PIXEL_DATA(c_pix),
        .DISPLAY_EN(c_de), .HSYNC(c_hs), .VSYNC(c_vs), .R(c_r), .G(c_g), .B(c_b)
    );

    vga_timing_pipe #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIX_LATENCY(2), .CNT_W(11)
    ) u_pol (
        .FCLK(fclk), .RST_IN(p_rst), .PIX_CE(p_ce), .REQ_X(p_x), .REQ_Y(p_y),
        .REQ_VALID(p_rv), .LINE_START(p_ls), .FRAME_START(p_fs), .PIXEL_DATA(p_pix),
        .DISPLAY_EN(p_de), .HSYNC(p_hs), .VSYNC(p_vs), .R(p_r), .G(p_g), .B(p_b)
    );

    vga_timing_pipe u_xga (
        .FCLK(fclk), .RST_IN(x_rst), .PIX_CE(x_ce), .REQ_X(x_x), .REQ_Y(x_y),
        .REQ_VALID(x_rv), .LINE_START(x_ls), .FRAME_START(x_fs), .PIXEL_DATA(x_pix),
        .DISPLAY_EN(x_de), .HSYNC(x_hs), .VSYNC(x_vs), .R(x_r), .G(x_g), .B(x_b)
    );

    // ---------------- reference model ----------------
    // n = pixel-cycles since reset release (0 = in reset). REQ shows linear
    // position n-1; outputs show position n-1-LAG, blank before that.
    function automatic obs_t model(input int n,
                                   input int hv, input int hf, input int hsw, input int hb,
                                   input int vv, input int vf, input int vsw, input int vb,
                                   input bit pol, input bit pattern, input logic [7:0] cpix);
        obs_t e;
        int ht, vt, p, q, x, y;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        e = '0;
        e.hs = ~pol;
        e.vs = ~pol;
        if (n > 0) begin
            p = n - 1;
            x = p % ht;
            y = (p / ht) % vt;
            e.x  = 11'(x);
            e.y  = 11'(y);
            e.rv = (x < hv) && (y < vv);
            e.ls = (x == 0);
            e.fs = (x == 0) && (y == 0);
            q = n - 1 - LAG;
            if (q >= 0) begin
                x = q % ht;
                y = (q / ht) % vt;
                e.de = (x < hv) && (y < vv);
                e.hs = (x >= hv + hf && x < hv + hf + hsw) ? pol : ~pol;
                e.vs = (y >= vv + vf && y < vv + vf + vsw) ? pol : ~pol;
                if (e.de) e.rgb = pattern ? {3'(y), 3'(x), 2'b01} : cpix;
            end
        end
        return e;
    endfunction

    function automatic obs_t mk(input logic [10:0] x, input logic [10:0] y,
                                input logic rv, input logic ls, input logic fs,
                                input logic de, input logic hs, input logic vs,
                                input logic [7:0] rgb);
        obs_t o;
        o = '{x: x, y: y, rv: rv, ls: ls, fs: fs, de: de, hs: hs, vs: vs, rgb: rgb};
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("x=%0d y=%0d rv=%b ls=%b fs=%b de=%b hs=%b vs=%b rgb=%h",
                         o.x, o.y, o.rv, o.ls, o.fs, o.de, o.hs, o.vs, o.rgb);
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got {%s} expected {%s}", name, $time, fmt(act), fmt(exp));
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- scoreboard queues ----------------
    obs_t q_s[$];
    obs_t q_c[$];
    obs_t q_p[$];
    obs_t q_x[$];

    // XGA line statistics
    bit x_ls_seen = 1'b0;
    int x_period  = 0;
    int x_de_cnt  = 0;
    int x_lines   = 0;

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge fclk);
            #2;
            if (q_s.size() != 0)
                check_obs("small", mk(s_x, s_y, s_rv, s_ls, s_fs, s_de, s_hs, s_vs, {s_r, s_g, s_b}), q_s.pop_front());
            if (q_c.size() != 0)
                check_obs("clk_enable", mk(c_x, c_y, c_rv, c_ls, c_fs, c_de, c_hs, c_vs, {c_r, c_g, c_b}), q_c.pop_front());
            if (q_p.size() != 0)
                check_obs("polarity_reset", mk(p_x, p_y, p_rv, p_ls, p_fs, p_de, p_hs, p_vs, {p_r, p_g, p_b}), q_p.pop_front());
            if (q_x.size() != 0) begin
                check_obs("xga", mk(x_x, x_y, x_rv, x_ls, x_fs, x_de, x_hs, x_vs, {x_r, x_g, x_b}), q_x.pop_front());
                if (x_ls) begin
                    if (x_ls_seen) begin
                        check_int("xga_line_period", x_period, 1328);
                        check_int("xga_line_active", x_de_cnt, 1024);
                        x_lines++;
                    end
                    x_ls_seen = 1'b1;
                    x_period  = 0;
                    x_de_cnt  = 0;
                end
                x_period++;
                if (x_de) x_de_cnt++;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n_s, n_c, n_p, n_x;
        bit pol_done;
        logic [7:0] h0, h1;
        n_s = 0; n_c = 0; n_p = 0; n_x = 0;
        pol_done = 1'b0;
        h0 = 8'h00; h1 = 8'h00;
        s_rst = 1'b1; s_ce = 1'b1; s_pix = 8'h00;
        c_rst = 1'b1; c_ce = 1'b1; c_pix = 8'hA5;
        p_rst = 1'b1; p_ce = 1'b1; p_pix = 8'h3C;
        x_rst = 1'b1; x_ce = 1'b1; x_pix = 8'hFF;

        for (int c = 0; c < NCYC; c++) begin
            @(negedge fclk);

            // Small mode: 3 reset cycles, pattern source returns data 2 cycles late.
            s_rst = (c < 3);
            s_pix = h1;
            h1 = h0;
            h0 = {s_y[2:0], s_x[2:0], 2'b01};
            n_s = s_rst ? 0 : n_s + 1;
            q_s.push_back(model(n_s, 8, 2, 3, 3, 4, 1, 2, 1, 1'b0, 1'b1, 8'h00));

            // Enable toggling 1,0,1,0 (also during reset).
            c_rst = (c < 4);
            c_ce  = (c % 2 == 0);
            if (c_rst) n_c = 0;
            else if (c_ce) n_c = n_c + 1;
            q_c.push_back(model(n_c, 8, 2, 3, 3, 4, 1, 2, 1, 1'b0, 1'b0, 8'hA5));

            // Active-high syncs; one-cycle reset once REQ shows (5,2).
            p_rst = (c < 2) || (!pol_done && n_p == 38);
            if (c >= 2 && p_rst) pol_done = 1'b1;
            n_p = p_rst ? 0 : n_p + 1;
            q_p.push_back(model(n_p, 8, 2, 3, 3, 4, 1, 2, 1, 1'b1, 1'b0, 8'h3C));

            // Default XGA mode, first few lines.
            x_rst = (c < 2);
            n_x = x_rst ? 0 : n_x + 1;
            q_x.push_back(model(n_x, 1024, 24, 136, 144, 768, 3, 6, 29, 1'b0, 1'b0, 8'hFF));
        end

        repeat (3) @(posedge fclk);
        #3;
        check_int("queues_drained", q_s.size() + q_c.size() + q_p.size() + q_x.size(), 0);
        check_int("xga_lines_measured", x_lines, 3);
        check_int("pol_reset_issued", int'(pol_done), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_pipe.md
Name: vga_timing_pipe

Overview:
- Parametrised successor to the fixed 1024x768 VGA sync generator: one block holds the horizontal and vertical counters, programmable porches and sync polarities, and RGB width.
- Issues pixel requests PIX_LATENCY pixel-cycles ahead of display, then delays sync and blank so returning PIXEL_DATA lines up with them.
- Sits between the pixel clock domain and the framebuffer/pattern source; drives the VGA connector.

Parameters:
- H_VISIBLE, 1024, active pixels per line
- H_FRONT, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width (pixels)
- H_BACK, 144, horizontal back porch (pixels)
- V_VISIBLE, 768, active lines per frame
- V_FRONT, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BACK, 29, vertical back porch (lines)
- HSYNC_POL, 0, active level of HSYNC (0 = active-low)
- VSYNC_POL, 0, active level of VSYNC
- PIX_LATENCY, 2, pixel-cycles from request to PIXEL_DATA valid; range 1..8
- CNT_W, 11, counter and position width; must hold H_TOTAL-1 and V_TOTAL-1
- R_W, 3; G_W, 3; B_W, 2, colour component widths

Ports:
- FCLK  in  1  pixel clock
- RST_IN  in  1  synchronous reset, active-high
- PIX_CE  in  1  pixel-cycle enable; all state advances only when high
- REQ_X  out  CNT_W  requested pixel column
- REQ_Y  out  CNT_W  requested pixel row
- REQ_VALID  out  1  REQ_X/REQ_Y lie in the visible area
- LINE_START  out  1  one-pixel-cycle pulse at the request for column 0 of any line
- FRAME_START  out  1  one-pixel-cycle pulse at the request for (0,0)
- PIXEL_DATA  in  R_W+G_W+B_W  pixel colour, packed as {R,G,B}
- DISPLAY_EN  out  1  delayed visible flag, aligned with R/G/B
- HSYNC  out  1  horizontal sync
- VSYNC  out  1  vertical sync
- R  out  R_W  red
- G  out  G_W  green
- B  out  B_W  blue

Behaviour:
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL is defined the same way from the V_ parameters.
- Line order is: visible [0,H_VISIBLE), front porch, sync, back porch. Frame order is the same for lines.
- Reset (RST_IN=1 on a rising FCLK, regardless of PIX_CE):
  - internal h/v counters go to 0,0 and the delay line is cleared to the blank state;
  - REQ_X=0, REQ_Y=0, REQ_VALID=0, LINE_START=0, FRAME_START=0, DISPLAY_EN=0;
  - R/G/B=0, HSYNC=~HSYNC_POL, VSYNC=~VSYNC_POL.
- Reset mid-line or mid-frame aborts immediately; there is no partial-frame flush.
- First PIX_CE edge after reset deassert presents (0,0) with REQ_VALID=1, LINE_START=1, FRAME_START=1.
- Counters:
  - h increments on each PIX_CE edge and wraps H_TOTAL-1 -> 0.
  - v increments only on the h wrap and wraps V_TOTAL-1 -> 0.
  - A simultaneous h and v wrap returns to (0,0) and raises FRAME_START.
- Request stage (registered):
  - REQ_X/REQ_Y are the current counters.
  - REQ_VALID = (h<H_VISIBLE)&&(v<V_VISIBLE).
  - Raw hsync active while H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC; raw vsync uses the same rule on v.
  - REQ_X/REQ_Y are driven during blanking too; sources ignore them when REQ_VALID=0.
- Delay line:
  - {REQ_VALID, raw hsync, raw vsync} shift through PIX_LATENCY stages, each advancing only on PIX_CE.
  - PIXEL_DATA for a request issued at pixel-cycle k is sampled on the PIX_CE edge ending pixel-cycle k+PIX_LATENCY.
- Output register, loaded on that same edge:
  - DISPLAY_EN = delayed valid;
  - {R,G,B} = delayed valid ? PIXEL_DATA : 0;
  - HSYNC/VSYNC = delayed raw sync XNOR polarity.
- End-to-end alignment: every output reflects position P exactly PIX_LATENCY+1 pixel-cycles after REQ shows P.
- PIX_CE=0: every register holds, including outputs. Reset still applies.
- LINE_START and FRAME_START are high for exactly one PIX_CE-qualified cycle. With PIX_CE low they hold their value and are not re-triggered.

Decomposition:
- Package vga_timing_pkg: mode constants (XGA_1024x768_60 set, VGA_640x480_60 set); the packed pixel-width function; a total-length helper function.
- One natural sub-module, vga_axis_counter: a single-axis counter with visible/sync decode, instantiated once for h and once for v (v enabled by the h wrap).
- Delay line and output register stay in the top module.

Test Plan:
- Reset timing:
  - Stimulus: small mode H=8/2/3/3, V=4/1/2/1, PIX_LATENCY=2, PIX_CE=1, reset 3 cycles, release.
  - Response: all outputs at their reset values during reset; first edge after release shows REQ=(0,0), REQ_VALID=1, FRAME_START=1; DISPLAY_EN rises exactly 3 cycles later.
- Line/frame periods (same mode):
  - HSYNC low for 3 of every 16 cycles, starting at output-aligned h=10.
  - VSYNC low for 2 lines (32 cycles) of every 128.
  - FRAME_START period is 128 cycles.
- Data alignment:
  - Stimulus: source returns PIXEL_DATA = {REQ_Y[2:0], REQ_X[2:0], 2'b01} delayed 2 cycles.
  - Response: R/G/B match position on every DISPLAY_EN=1 cycle, and are 0 otherwise.
- Clock enable:
  - Stimulus: PIX_CE toggles 1,0,1,0.
  - Response: all periods exactly double; outputs hold during CE=0; LINE_START stays high 2 FCLK cycles but counts once.
- Polarity and mid-frame reset:
  - Stimulus: HSYNC_POL=1, VSYNC_POL=1; then assert reset at v=2, h=5 for 1 cycle.
  - Response: syncs idle low and pulse high; after reset, sequence restarts at (0,0) with no stale DISPLAY_EN from the old frame.
- Full mode:
  - Stimulus: default XGA parameters, one frame.
  - Response: 1328 cycles per line, 806 lines, and 1024x768 DISPLAY_EN cycles per frame.
